mem_access_unit: RTL

//  Load/store front end between the CPU memory stage and the 1024x32 byte-lane data RAM.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states
// and the byte-lane select patterns driven to the data RAM.
package mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SEL_B0 = 4'b0001;
  localparam logic [3:0] SEL_B1 = 4'b0010;
  localparam logic [3:0] SEL_B2 = 4'b0100;
  localparam logic [3:0] SEL_B3 = 4'b1000;
  localparam logic [3:0] SEL_H0 = 4'b0011;
  localparam logic [3:0] SEL_H1 = 4'b1100;
  localparam logic [3:0] SEL_W  = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte-lane select, store-data replication,
// load-data extraction with sign/zero extension, and alignment checking.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic        uns,
  input  logic [31:0] dout,
  output logic [3:0]  sel,
  output logic [31:0] din,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    sel       = '0;
    din       = '0;
    rdata_ext = '0;
    misalign  = 1'b0;
    b         = dout[7:0];
    h         = off[1] ? dout[31:16] : dout[15:0];
    case (off)
      2'd0:    b = dout[7:0];
      2'd1:    b = dout[15:8];
      2'd2:    b = dout[23:16];
      default: b = dout[31:24];
    endcase
    case (size)
      SIZE_B: begin
        case (off)
          2'd0:    sel = SEL_B0;
          2'd1:    sel = SEL_B1;
          2'd2:    sel = SEL_B2;
          default: sel = SEL_B3;
        endcase
        din       = {4{wdata[7:0]}};
        rdata_ext = {{24{b[7] & ~uns}}, b};
      end
      SIZE_H: begin
        sel       = off[1] ? SEL_H1 : SEL_H0;
        din       = {2{wdata[15:0]}};
        rdata_ext = {{16{h[15] & ~uns}}, h};
        misalign  = off[0];
      end
      SIZE_W: begin
        sel       = SEL_W;
        din       = wdata;
        rdata_ext = dout;
        misalign  = |off;
      end
      // SIZE_X is reported through the same error flag as misalignment
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end: accepts one request per handshake, performs a single
// RAM access cycle and returns a registered response with an error flag.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RAM_AW      = 10,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_we,
  output logic [3:0]        ram_sel,
  output logic              ram_ld,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; a response transfers where resp_valid and
  // resp_ready are both high. Neither side may retract while waiting.

  state_t state, state_nxt;

  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [RAM_AW+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [RAM_AW-1:0] addr_hold;
  logic [31:0]       din_hold;

  logic        idle, in_access, accept, range_err, req_err;
  logic [1:0]  a_size, a_off;
  logic [3:0]  a_sel;
  logic [31:0] a_din, a_rdata;
  logic        a_misalign;

  assign idle      = (state == IDLE);
  assign in_access = (state == ACCESS);
  assign accept    = req_valid & idle;

  // In IDLE the aligner judges the incoming request; afterwards it works on the held copy
  assign a_size = idle ? req_size      : r_size;
  assign a_off  = idle ? req_addr[1:0] : r_addr[1:0];

  mem_lane_align u_align (
    .size      (a_size),
    .off       (a_off),
    .wdata     (r_wdata),
    .uns       (r_uns),
    .dout      (ram_dout),
    .sel       (a_sel),
    .din       (a_din),
    .rdata_ext (a_rdata),
    .misalign  (a_misalign)
  );

  assign range_err = CHECK_RANGE && (req_addr[31:RAM_AW+2] != '0);
  assign req_err   = a_misalign | range_err;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_err ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready  = idle;
  assign resp_valid = (state == RESP);
  assign ram_we     = in_access & r_we;
  assign ram_ld     = in_access & ~r_we;
  assign ram_sel    = in_access ? a_sel : 4'b0000;
  assign ram_addr   = in_access ? r_addr[RAM_AW+1:2] : addr_hold;
  assign ram_din    = (in_access & r_we) ? a_din : din_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= SIZE_B;
      r_addr     <= '0;
      r_wdata    <= '0;
      addr_hold  <= '0;
      din_hold   <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r_we       <= req_we;
        r_uns      <= req_unsigned;
        r_size     <= req_size;
        r_addr     <= req_addr[RAM_AW+1:0];
        r_wdata    <= req_wdata;
        resp_err   <= req_err;
        resp_rdata <= '0;
      end
      if (in_access) begin
        addr_hold <= r_addr[RAM_AW+1:2];
        if (r_we) din_hold <= a_din;
        else      resp_rdata <= a_rdata;
      end
    end
  end

endmodule
